// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared types and defaults for the adder sequencing controller.
package adder_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ACK   = 3'd4
  } state_e;

  // Opcode carried from control register bit 1
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Default watchdog limit in cycles spent in ISSUE+WAIT
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/adder_ctrl_if.sv
// adder_ctrl_if: valid/ready + done handshake between the controller (master)
// and the arithmetic unit (slave). Signal names are seen from the controller.
interface adder_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              o_au_valid;
  logic              i_au_ready;
  logic              o_au_op;
  logic [DATA_W-1:0] o_au_a;
  logic [DATA_W-1:0] o_au_b;
  logic              i_au_done;
  logic [DATA_W-1:0] i_au_result;
  logic              i_au_carry;

  modport master (
    output o_au_valid,
    output o_au_op,
    output o_au_a,
    output o_au_b,
    input  i_au_ready,
    input  i_au_done,
    input  i_au_result,
    input  i_au_carry
  );

  modport slave (
    input  o_au_valid,
    input  o_au_op,
    input  o_au_a,
    input  o_au_b,
    output i_au_ready,
    output i_au_done,
    output i_au_result,
    output i_au_carry
  );

endinterface

// File: rtl/adder_ctrl_wdog.sv
// adder_ctrl_wdog: cycle counter for the optional watchdog (ADDER_CTRL_WDOG_EN).
// clr_i restarts the count, en_i advances it, expired_o flags the cycle in
// which the LIMIT-th enabled cycle is being spent.
module adder_ctrl_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on request, otherwise count enabled cycles and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q >= LIM_M1);

endmodule

// File: rtl/adder_ctrl.sv
// adder_ctrl: sequencing controller for the AXI4-Lite adder peripheral.
// Latches operands on the software start bit, hands the operation to the
// arithmetic unit, writes the result back and clears the start bit.
// Optional watchdog compiled in with `define ADDER_CTRL_WDOG_EN.
module adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              i_start,
  input  logic              i_op,
  input  logic [DATA_W-1:0] i_r0,
  input  logic [DATA_W-1:0] i_r1,
  output logic              o_enable_ctrl_write,
  output logic [DATA_W-1:0] o_busr,
  output logic              o_rst_start,
  adder_ctrl_if.master      au,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_carry,
  output logic              o_err_timeout,
  output logic [CNT_W-1:0]  o_op_count
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("adder_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cap_carry_q, cap_carry_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wdog_exp;
  logic              timeout_err;

`ifdef ADDER_CTRL_WDOG_EN
  logic wdog_clr;
  logic wdog_en;
  logic err_q, err_d;

  // Counter restarts whenever a new operation is accepted
  assign wdog_clr = (state_q == IDLE) && i_start;
  assign wdog_en  = (state_q == ISSUE) || (state_q == WAIT);

  adder_ctrl_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (ACLK),
    .rst_ni    (ARSTn),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_exp)
  );

  // Sticky error: cleared by the next start, set when ISSUE/WAIT bail out to ACK
  always_comb begin
    err_d = err_q;
    if (wdog_clr) begin
      err_d = 1'b0;
    end else if (wdog_en && (state_d == ACK)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign wdog_exp    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state and datapath captures; operands only load in IDLE so later
  // register changes cannot disturb a running operation
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    cap_carry_d = cap_carry_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_r0;
          b_d     = i_r1;
          op_d    = op_e'(i_op);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (au.i_au_ready) begin
          state_d = WAIT;
        end else if (wdog_exp) begin
          state_d = ACK;
        end
      end
      WAIT: begin
        if (au.i_au_done) begin
          res_d       = au.i_au_result;
          cap_carry_d = au.i_au_carry;
          state_d     = WRITE;
        end else if (wdog_exp) begin
          state_d = ACK;
        end
      end
      WRITE: begin
        carry_d = cap_carry_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation at once
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      res_q       <= '0;
      cap_carry_q <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      cap_carry_q <= cap_carry_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
    end
  end

  // Moore outputs: strobes decoded from state, data from registers
  assign au.o_au_valid         = (state_q == ISSUE);
  assign au.o_au_op            = op_q;
  assign au.o_au_a             = a_q;
  assign au.o_au_b             = b_q;
  assign o_enable_ctrl_write   = (state_q == WRITE);
  assign o_busr                = res_q;
  assign o_rst_start           = (state_q == ACK);
  assign o_done                = (state_q == ACK) && !timeout_err;
  assign o_busy                = (state_q != IDLE);
  assign o_carry               = carry_q;
  assign o_err_timeout         = timeout_err;
  assign o_op_count            = cnt_q;

endmodule
